// File: rtl/dvi_ddr_rx_packer.sv
// dvi_ddr_rx_packer: decode 12-bit DDR DVI pixels to RGB, pack two per 64-bit word and buffer with SOF/EOL tags
module dvi_ddr_rx_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 12,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [11:0]      d_rise,
  input  logic [11:0]      d_fall,
  input  logic             de,
  input  logic             hs,
  input  logic             vs,
  output logic [63:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [CNT_W-1:0] line_pixels
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [11:0] rise_q, fall_q;
  logic de1, hs1, vs1;
  logic phase, hold_v, sof_pend, de_q, vs_q;
  logic [23:0] lo;
  logic [63:0] hold;
  logic [CNT_W-1:0] cnt;
  logic [65:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [23:0] pixel;
  logic [65:0] wword, head;
  logic de_fall, vs_act, vsq_act, wr, empty, full, rd, push, drop, unused_hs;
  assign unused_hs = hs1;
  assign pixel = {rise_q[11:8], fall_q[3:0], rise_q[3:0], rise_q[7:4], fall_q[7:4], fall_q[11:8]};
  assign vs_act = (VS_ACTIVE_LOW != 0) ? ~vs1 : vs1;
  assign vsq_act = (VS_ACTIVE_LOW != 0) ? ~vs_q : vs_q;
  assign de_fall = de_q & ~de1;
  assign wr = (de1 & ~phase & hold_v) | de_fall;
  assign wword = {sof_pend, de_fall, (de_fall & phase) ? {40'h0, lo} : hold};
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd = ~empty & m_ready;
  assign push = wr & (~full | rd);
  assign drop = wr & full & ~rd;
  assign head = mem[rptr[AW-1:0]];
  assign m_valid = ~empty;
  assign m_sof = ~empty & head[65];
  assign m_eol = ~empty & head[64];
  assign m_data = empty ? 64'h0 : head[63:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
    end else begin
      rise_q <= d_rise;
      fall_q <= d_fall;
      de1 <= de;
      hs1 <= hs;
      vs1 <= vs;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      phase <= 1'b0;
      hold_v <= 1'b0;
      sof_pend <= 1'b0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
      lo <= '0;
      hold <= '0;
      cnt <= '0;
      line_pixels <= '0;
      overflow <= 1'b0;
    end else begin
      de_q <= de1;
      vs_q <= vs1;
      sof_pend <= (vs_act & ~vsq_act) | (sof_pend & ~wr);
      overflow <= ~clr_overflow & (overflow | drop);
      if (de1) begin
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
        phase <= ~phase;
        if (!phase) begin
          lo <= pixel;
          hold_v <= 1'b0;
        end else begin
          hold <= {8'h0, pixel, 8'h0, lo};
          hold_v <= 1'b1;
        end
      end else if (de_q) begin
        line_pixels <= cnt;
        cnt <= '0;
        phase <= 1'b0;
        hold_v <= 1'b0;
      end
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(rd);
    end
  always_ff @(posedge clock)
    if (push) mem[wptr[AW-1:0]] <= wword;
endmodule

// File: tb/tb_dvi_ddr_rx_packer.sv
// tb_dvi_ddr_rx_packer: scoreboard bench for the DVI DDR receive packer
module tb_dvi_ddr_rx_packer;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [11:0] d_rise = '0, d_fall = '0;
  logic de = 1'b0, hs = 1'b0, vs = 1'b1, m_ready = 1'b0, clr_overflow = 1'b0;
  logic [63:0] m_data;
  logic m_valid, m_sof, m_eol, overflow;
  logic [11:0] line_pixels;
  int tests = 0, fails = 0;
  logic [65:0] q[$];
  logic [23:0] pix [0:63];
  logic sof_nx = 1'b0;
  bit rnd = 1'b0;
  always #5 clock = ~clock;
  dvi_ddr_rx_packer dut (
    .clock(clock), .reset_n(reset_n), .d_rise(d_rise), .d_fall(d_fall),
    .de(de), .hs(hs), .vs(vs), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .overflow(overflow),
    .clr_overflow(clr_overflow), .line_pixels(line_pixels)
  );
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clock)
    if (reset_n && m_valid && m_ready) begin
      if (q.size() == 0) check("extra_word", 66'(q.size()), 66'd1);
      else check("word", {m_sof, m_eol, m_data}, q.pop_front());
    end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (rnd) begin
        m_ready = 1'($urandom_range(0, 1));
        hs = 1'($urandom_range(0, 1));
      end
    end
  endtask
  function automatic logic [23:0] enc(input logic [23:0] p);
    return {p[23:20], p[11:8], p[15:12], p[3:0], p[7:4], p[19:16]};
  endfunction
  task automatic send(input int n, input int gap, input int max_w);
    int w = 0;
    for (int i = 0; i < n; i += 2) begin
      if (w < max_w) begin
        q.push_back({sof_nx, i + 2 >= n, (i + 1 < n) ? {8'h0, pix[i+1], 8'h0, pix[i]} : {40'h0, pix[i]}});
        sof_nx = 1'b0;
      end
      w++;
    end
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      {d_rise, d_fall} = enc(pix[i]);
      step();
    end
    de = 1'b0;
    step(gap);
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && (q.size() != 0 || m_valid); i++) step();
    check("drain", 66'(q.size()), 66'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    step(3);
    reset_n = 1'b1;
    step(2);
    m_ready = 1'b1;
    pix[0] = 24'h123456;
    pix[1] = 24'hABCDEF;
    q.push_back({2'b01, 64'h00ABCDEF_00123456});
    send(2, 4, 0);
    drain();
    check("lp2", 66'(line_pixels), 66'd2);
    pix[0] = 24'h010203;
    pix[1] = 24'h040506;
    pix[2] = 24'h070809;
    q.push_back({2'b00, 64'h00040506_00010203});
    q.push_back({2'b01, 64'h00000000_00070809});
    send(3, 4, 0);
    drain();
    check("lp3", 66'(line_pixels), 66'd3);
    vs = 1'b0;
    step(2);
    vs = 1'b1;
    step(2);
    sof_nx = 1'b1;
    for (int i = 0; i < 4; i++) pix[i] = 24'($urandom);
    send(4, 3, 99);
    for (int i = 0; i < 4; i++) pix[i] = 24'($urandom);
    send(4, 3, 99);
    drain();
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) pix[i] = 24'($urandom);
    send(40, 4, 16);
    step(2);
    check("ovf_set", 66'(overflow), 66'd1);
    check("full_valid", 66'(m_valid), 66'd1);
    check("lp40", 66'(line_pixels), 66'd40);
    m_ready = 1'b1;
    drain();
    check("ovf_sticky", 66'(overflow), 66'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clr", 66'(overflow), 66'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) pix[i] = 24'($urandom);
    send(4, 3, 99);
    check("pre_valid", 66'(m_valid), 66'd1);
    for (int i = 0; i < 3; i++) begin
      de = 1'b1;
      {d_rise, d_fall} = enc(24'($urandom));
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check("rst_data", 66'(m_data), 66'd0);
    check("rst_ctl", 66'({m_valid, m_sof, m_eol, overflow, line_pixels}), 66'd0);
    q.delete();
    sof_nx = 1'b0;
    de = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    m_ready = 1'b1;
    pix[0] = 24'h0A0B0C;
    pix[1] = 24'h0D0E0F;
    send(2, 3, 99);
    drain();
    check("lp_after_rst", 66'(line_pixels), 66'd2);
    rnd = 1'b1;
    for (int l = 0; l < 1000; l++) begin
      int n;
      for (int k = 0; k < 1000 && q.size() > 8; k++) step();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) pix[i] = 24'($urandom);
      send(n, $urandom_range(2, 6), 99);
    end
    drain();
    rnd = 1'b0;
    m_ready = 1'b1;
    drain();
    check("no_ovf", 66'(overflow), 66'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
